// File: rtl/car_link_responder.sv
// Car-side UART link endpoint: decodes validated 8N1 command bytes into motion/barrier
// outputs and periodically returns a status byte carrying the obstacle detector bits.
module car_link_responder #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int TX_PERIOD    = 1_000_000,
  parameter int WDOG_CYCLES  = 50_000_000
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       rx,
  input  logic [3:0] det_in,
  output logic       tx,
  output logic       cmd_fwd,
  output logic       cmd_back,
  output logic       cmd_left,
  output logic       cmd_right,
  output logic       cmd_place,
  output logic       cmd_destroy,
  output logic       cmd_valid,
  output logic       frame_err,
  output logic       link_alive
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = $clog2(TX_PERIOD);
  localparam int WW = $clog2(WDOG_CYCLES);

  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_HALF  = BW'(CLKS_PER_BIT / 2);
  localparam logic [PW-1:0] PER_LAST  = PW'(TX_PERIOD - 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  // ---------------- receive path ----------------
  logic [1:0]    rx_sync;
  logic          rx_s;
  rx_state_t     rx_state, rx_next;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          byte_done, stop_err, accept, reject;

  // Synchronizer powers up at the idle level so leaving reset never looks like a start bit.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) rx_sync <= 2'b11;
    else      rx_sync <= {rx_sync[0], rx};
  end

  assign rx_s = rx_sync[1];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    rx_next   = rx_state;
    byte_done = 1'b0;
    stop_err  = 1'b0;
    case (rx_state)
      RX_IDLE:  if (!rx_s) rx_next = RX_START;
      RX_START: if (rx_cnt == BIT_HALF) rx_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_cnt == BIT_LAST && rx_idx == 3'd7) rx_next = RX_STOP;
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          if (rx_s) begin
            rx_next   = RX_IDLE;
            byte_done = 1'b1;
          end else begin
            rx_next  = RX_WAIT;
            stop_err = 1'b1;
          end
        end
      end
      RX_WAIT:  if (rx_s) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_state <= rx_next;
      // Counter restarts on every state change and every bit boundary, so data samples
      // fall a whole bit apart starting from the middle of the start bit.
      if (rx_next != rx_state || rx_state == RX_IDLE || rx_state == RX_WAIT ||
          rx_cnt == BIT_LAST)
        rx_cnt <= '0;
      else
        rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == RX_START) begin
        rx_idx <= '0;
      end else if (rx_state == RX_DATA && rx_cnt == BIT_LAST) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_idx <= rx_idx + 1'b1;
      end
    end
  end

  assign accept = byte_done && rx_sh[7:6] == 2'b10 && !(rx_sh[0] && rx_sh[1]);
  assign reject = (byte_done && !accept) || stop_err;

  // ---------------- command outputs and watchdog ----------------
  logic [5:0]    cmd;
  logic [WW-1:0] wdog;

  assign {cmd_destroy, cmd_place, cmd_right, cmd_left, cmd_back, cmd_fwd} = cmd;

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      cmd        <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      link_alive <= 1'b0;
      wdog       <= '0;
    end else begin
      cmd_valid <= accept;
      frame_err <= reject;
      if (accept) begin
        cmd        <= rx_sh[5:0];
        link_alive <= 1'b1;
        wdog       <= '0;
      end else if (link_alive) begin
        if (wdog == WDOG_LAST) begin
          cmd        <= '0;
          link_alive <= 1'b0;
          wdog       <= '0;
        end else begin
          wdog <= wdog + 1'b1;
        end
      end
    end
  end

  // ---------------- transmit path ----------------
  logic [PW-1:0] per_cnt;
  logic          terminal, pending, launch, tx_bit;
  logic [7:0]    status, tx_sh;
  tx_state_t     tx_state, tx_next;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_idx;

  assign terminal = (per_cnt == PER_LAST);
  assign launch   = (tx_state == TX_IDLE) && pending;

  always_comb begin
    tx_next = tx_state;
    tx_bit  = 1'b1;
    case (tx_state)
      TX_IDLE:  if (pending) tx_next = TX_START;
      TX_START: begin
        tx_bit = 1'b0;
        if (tx_cnt == BIT_LAST) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_bit = tx_sh[0];
        if (tx_cnt == BIT_LAST && tx_idx == 3'd7) tx_next = TX_STOP;
      end
      TX_STOP:  if (tx_cnt == BIT_LAST) tx_next = TX_IDLE;
      default:  tx_next = TX_IDLE;
    endcase
  end

  // The frame shifts out of its own copy, so later status updates never touch it.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      per_cnt  <= '0;
      status   <= '0;
      pending  <= 1'b0;
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx       <= 1'b1;
    end else begin
      per_cnt <= terminal ? '0 : per_cnt + 1'b1;
      if (terminal) begin
        status  <= {4'b0000, det_in};
        pending <= 1'b1;
      end else if (launch) begin
        pending <= 1'b0;
      end
      tx_state <= tx_next;
      tx       <= tx_bit;
      if (tx_state == TX_IDLE || tx_cnt == BIT_LAST) tx_cnt <= '0;
      else                                           tx_cnt <= tx_cnt + 1'b1;
      if (launch) begin
        tx_sh  <= status;
        tx_idx <= '0;
      end else if (tx_state == TX_DATA && tx_cnt == BIT_LAST) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

endmodule
